keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time. It reads the
//   row lines back through a two-flop synchronizer and debounces whole scans
//   before it accepts a key. For each accepted press it delivers one
//   key_valid pulse together with the hex code of the key.
//
//   Ports:
//     clk        system clock
//     rst        synchronous reset, active-high
//     row[3:0]   keypad rows, active-low, asynchronous to clk
//     col[3:0]   column strobes, active-low one-hot
//     key_code   code of the last accepted key, held after release
//     key_valid  one-cycle pulse when a key is accepted
//     key_held   high while the accepted key is down
//
//   Optional feature macro: KEYPAD_REPEAT_EN
//     When defined, holding a key re-pulses key_valid every REPEAT_SCANS
//     full scans. When undefined, each press produces exactly one pulse and
//     the REPEAT_SCANS parameter does not exist.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_SCANS = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DBC_LAST   = CW'(DEBOUNCE_SCANS - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [3:0]    rowMeta_q, rowSync_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    colIdx_q, colIdx_d;
  logic [15:0]   acc_q, acc_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] dbc_q, dbc_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d;
  logic          valid_q, validPulse;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  logic        sampleEn, scanEnd;
  logic [15:0] colHits, scanAll;
  logic [4:0]  hitCount;
  logic [3:0]  hitIdx;
  logic [3:0]  hitCode;
  logic        isNone, isSingle;

  // Key code for sample bit index {row, col}.
  function automatic logic [3:0] codeMap(input logic [3:0] idx);
    case (idx)
      4'd0:    codeMap = 4'h1;
      4'd1:    codeMap = 4'h2;
      4'd2:    codeMap = 4'h3;
      4'd3:    codeMap = 4'hA;
      4'd4:    codeMap = 4'h4;
      4'd5:    codeMap = 4'h5;
      4'd6:    codeMap = 4'h6;
      4'd7:    codeMap = 4'hB;
      4'd8:    codeMap = 4'h7;
      4'd9:    codeMap = 4'h8;
      4'd10:   codeMap = 4'h9;
      4'd11:   codeMap = 4'hC;
      4'd12:   codeMap = 4'hE;
      4'd13:   codeMap = 4'h0;
      4'd14:   codeMap = 4'hF;
      default: codeMap = 4'hD;
    endcase
  endfunction

  // Rows are asynchronous, so they pass through two flops before any use.
  // A released keypad reads all-ones, which is the reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
    end else begin
      rowMeta_q <= row;
      rowSync_q <= rowMeta_q;
    end
  end

  // The last dwell cycle of each column is also its sample cycle. Sampling
  // there leaves the synchronizer time to settle after the column changed.
  assign sampleEn = (dwell_q == DWELL_LAST);
  assign scanEnd  = sampleEn && (colIdx_q == 2'd3);
  assign col      = ~(4'b0001 << colIdx_q);

  always_comb begin
    dwell_d  = dwell_q + DW'(1);
    colIdx_d = colIdx_q;
    if (sampleEn) begin
      dwell_d  = '0;
      colIdx_d = colIdx_q + 2'd1;
    end
  end

  // Merge the current column's pressed rows into the scan image.
  // scanAll is the complete 16-key picture at scan-end.
  always_comb begin
    logic [3:0] bitIdx;
    colHits = '0;
    bitIdx  = '0;
    for (int r = 0; r < 4; r++) begin
      bitIdx          = {2'(r), colIdx_q};
      colHits[bitIdx] = ~rowSync_q[2'(r)];
    end
    scanAll = acc_q | colHits;
    acc_d   = acc_q;
    if (scanEnd) begin
      acc_d = '0;
    end else if (sampleEn) begin
      acc_d = scanAll;
    end
  end

  // Classify the finished scan as none, single key or multiple keys.
  always_comb begin
    logic [3:0] idx;
    hitCount = '0;
    hitIdx   = '0;
    idx      = '0;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      if (scanAll[idx]) begin
        hitCount = hitCount + 5'd1;
        hitIdx   = idx;
      end
    end
    isNone   = (hitCount == 5'd0);
    isSingle = (hitCount == 5'd1);
    hitCode  = codeMap(hitIdx);
  end

  // The debounce FSM moves only at scan-end. Both press and release need
  // DEBOUNCE_SCANS matching scans. Once a key is accepted, other keys are
  // ignored until the keypad reads fully released.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    dbc_d      = dbc_q;
    code_d     = code_q;
    held_d     = held_q;
    validPulse = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
`endif
    if (scanEnd) begin
      case (state_q)
        IDLE: begin
          if (isSingle) begin
            cand_d  = hitCode;
            dbc_d   = CW'(1);
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (isSingle && (hitCode == cand_q)) begin
            if (dbc_q == DBC_LAST) begin
              state_d    = PRESSED;
              code_d     = cand_q;
              held_d     = 1'b1;
              validPulse = 1'b1;
              dbc_d      = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d      = '0;
`endif
            end else begin
              dbc_d = dbc_q + CW'(1);
            end
          end else if (isSingle) begin
            cand_d = hitCode;
            dbc_d  = CW'(1);
          end else begin
            state_d = IDLE;
            dbc_d   = '0;
          end
        end
        PRESSED: begin
          if (isNone) begin
            dbc_d   = CW'(1);
            state_d = RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == REP_LAST) begin
              rep_d      = '0;
              validPulse = 1'b1;
            end else begin
              rep_d = rep_q + RW'(1);
            end
`endif
          end
        end
        RELEASE: begin
`ifdef KEYPAD_REPEAT_EN
          rep_d = '0;
`endif
          if (isNone) begin
            if (dbc_q == DBC_LAST) begin
              state_d = IDLE;
              held_d  = 1'b0;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_q + CW'(1);
            end
          end else begin
            state_d = PRESSED;
            dbc_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q  <= '0;
      colIdx_q <= '0;
      acc_q    <= '0;
      state_q  <= IDLE;
      cand_q   <= '0;
      dbc_q    <= '0;
      code_q   <= '0;
      held_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      dwell_q  <= dwell_d;
      colIdx_q <= colIdx_d;
      acc_q    <= acc_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      dbc_q    <= dbc_d;
      code_q   <= code_d;
      held_q   <= held_d;
      valid_q  <= validPulse;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_SCANS=3,
//   which gives 16 cycles per scan. A keypad model pulls row r low while
//   column c is strobed, for every key set in the keys mask (bit r*4+c).
//   Key changes are applied just after a scan-end edge, so each stimulus
//   step covers whole scans.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;

  int         checks = 0;
  int         failures = 0;
  int         pulseCnt;
  int         lastPulseEdge;
  int         doublePulses = 0;
  logic [3:0] lastCode;
  logic       prevValid;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          expPulses;
    logic [3:0]  expCode;
    logic        expHeld;
    int          expLastEdge;
  } vec_t;

  vec_t vecs[24];

  keypad_scanner #(
`ifdef KEYPAD_REPEAT_EN
    .REPEAT_SCANS(4),
`endif
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row to the strobed column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Hold the given key mask for nScans whole scans. Records every
  // key_valid pulse: the count, the cycle it appeared in and its code.
  task automatic applyStimulus(input logic [15:0] k, input int nScans);
    keys          = k;
    pulseCnt      = 0;
    lastPulseEdge = -1;
    for (int i = 0; i < nScans * 16; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) begin
        pulseCnt++;
        lastPulseEdge = i;
        lastCode      = key_code;
        if (prevValid) doublePulses++;
      end
      prevValid = key_valid;
    end
  endtask

  task automatic doReset();
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    prevValid = 1'b0;
  endtask

  initial begin
    logic [3:0] expCol;
    logic       anyActive;
    int         idx;

    rst      = 1'b1;
    keys     = '0;
    lastCode = '0;

    // Scan-level vectors. The bench starts in IDLE with key_code = 0.
    vecs[0]  = '{16'h0040, 2, 0, 4'h0, 1'b0, -1};
    vecs[1]  = '{16'h0040, 1, 1, 4'h6, 1'b1, 15};
    vecs[2]  = '{16'h0040, 2, 0, 4'h6, 1'b1, -1};
    vecs[3]  = '{16'h0000, 2, 0, 4'h6, 1'b1, -1};
    vecs[4]  = '{16'h0040, 2, 0, 4'h6, 1'b1, -1};
    vecs[5]  = '{16'h0000, 2, 0, 4'h6, 1'b1, -1};
    vecs[6]  = '{16'h0000, 1, 0, 4'h6, 1'b0, -1};
    vecs[7]  = '{16'h0020, 1, 0, 4'h6, 1'b0, -1};
    vecs[8]  = '{16'h0000, 1, 0, 4'h6, 1'b0, -1};
    vecs[9]  = '{16'h0020, 2, 0, 4'h6, 1'b0, -1};
    vecs[10] = '{16'h0000, 1, 0, 4'h6, 1'b0, -1};
    vecs[11] = '{16'h1000, 2, 0, 4'h6, 1'b0, -1};
    vecs[12] = '{16'h1000, 1, 1, 4'hE, 1'b1, 15};
    vecs[13] = '{16'h0000, 3, 0, 4'hE, 1'b0, -1};
    vecs[14] = '{16'h0001, 1, 0, 4'hE, 1'b0, -1};
    vecs[15] = '{16'h0002, 2, 0, 4'hE, 1'b0, -1};
    vecs[16] = '{16'h0002, 1, 1, 4'h2, 1'b1, 15};
    vecs[17] = '{16'h0000, 3, 0, 4'h2, 1'b0, -1};
    vecs[18] = '{16'h0008, 3, 1, 4'hA, 1'b1, 47};
    vecs[19] = '{16'h2008, 1, 0, 4'hA, 1'b1, -1};
    vecs[20] = '{16'h2000, 1, 0, 4'hA, 1'b1, -1};
    vecs[21] = '{16'h0000, 3, 0, 4'hA, 1'b0, -1};
    vecs[22] = '{16'h0021, 6, 0, 4'hA, 1'b0, -1};
    vecs[23] = '{16'h0000, 1, 0, 4'hA, 1'b0, -1};

    doReset();
    checkOutput("reset col", 32'(col), 32'h0000000E);
    checkOutput("reset key_valid", 32'(key_valid), 32'h0);
    checkOutput("reset key_held", 32'(key_held), 32'h0);
    checkOutput("reset key_code", 32'(key_code), 32'h0);

    // Idle scanning: each column is held low for four cycles in turn.
    anyActive = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      idx         = ((i + 1) / 4) % 4;
      expCol      = 4'hF;
      expCol[idx] = 1'b0;
      checkOutput($sformatf("idle col cyc%0d", i), 32'(col), 32'(expCol));
      if (key_valid || key_held || (key_code != 4'h0)) anyActive = 1'b1;
    end
    checkOutput("idle outputs quiet", 32'(anyActive), 32'h0);

    for (int v = 0; v < 24; v++) begin
      applyStimulus(vecs[v].keys, vecs[v].scans);
      checkOutput($sformatf("v%0d pulses", v), 32'(pulseCnt), 32'(vecs[v].expPulses));
      checkOutput($sformatf("v%0d key_code", v), 32'(key_code), 32'(vecs[v].expCode));
      checkOutput($sformatf("v%0d key_held", v), 32'(key_held), 32'(vecs[v].expHeld));
      if (vecs[v].expPulses > 0) begin
        checkOutput($sformatf("v%0d pulse code", v), 32'(lastCode), 32'(vecs[v].expCode));
      end
      if (vecs[v].expLastEdge >= 0) begin
        checkOutput($sformatf("v%0d pulse cycle", v), 32'(lastPulseEdge), 32'(vecs[v].expLastEdge));
      end
    end

    // Reset in the middle of debouncing key 9, part way through a scan.
    applyStimulus(16'h0400, 2);
    checkOutput("pre-reset pulses", 32'(pulseCnt), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid reset col", 32'(col), 32'h0000000E);
    checkOutput("mid reset key_code", 32'(key_code), 32'h0);
    checkOutput("mid reset key_held", 32'(key_held), 32'h0);
    checkOutput("mid reset key_valid", 32'(key_valid), 32'h0);
    rst       = 1'b0;
    prevValid = 1'b0;
    applyStimulus(16'h0400, 1);
    checkOutput("post reset no pulse", 32'(pulseCnt), 32'h0);
    applyStimulus(16'h0400, 2);
    checkOutput("post reset pulses", 32'(pulseCnt), 32'h1);
    checkOutput("post reset code", 32'(key_code), 32'h9);
    checkOutput("post reset pulse cycle", 32'(lastPulseEdge), 32'd31);
    applyStimulus(16'h0000, 3);
    checkOutput("post reset release", 32'(key_held), 32'h0);

    // Long hold of key D: repeats only when the feature is built in.
    applyStimulus(16'h8000, 3);
    checkOutput("D accept pulses", 32'(pulseCnt), 32'h1);
    checkOutput("D accept code", 32'(lastCode), 32'hD);
    applyStimulus(16'h8000, 12);
`ifdef KEYPAD_REPEAT_EN
    checkOutput("D hold repeats", 32'(pulseCnt), 32'd3);
    checkOutput("D repeat last cycle", 32'(lastPulseEdge), 32'd191);
    checkOutput("D repeat code", 32'(lastCode), 32'hD);
`else
    checkOutput("D hold repeats", 32'(pulseCnt), 32'd0);
`endif
    checkOutput("D held", 32'(key_held), 32'h1);
    applyStimulus(16'h0000, 3);
    checkOutput("D released", 32'(key_held), 32'h0);
    checkOutput("D code kept", 32'(key_code), 32'hD);

    checkOutput("single-cycle key_valid", 32'(doublePulses), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
